// File: rtl/state_compress.sv
// state_compress: compresses the Add result BRAM (96 words x 8 lanes x 16 bits)
// into ciphertext words. Words 0-63 (Bp) use KYBER_DU bits per lane, words
// 64-95 (V) use KYBER_DV bits per lane. One word per RD/WAIT/CALC/WR round.
// Optional macro STATE_COMPRESS_PIPE_EN inserts a CALC2 state that registers
// the per-lane quotients before packing (adds one cycle per word).

// Per-lane compression: round(x * 2^d / q) mod 2^d, with the division done
// as a reciprocal multiply plus a single remainder correction.
module state_compress_lane #(
    parameter int KYBER_Q  = 3329,
    parameter int KYBER_DU = 10,
    parameter int KYBER_DV = 4
) (
    input  logic [15:0]         x,
    input  logic                is_v,
    output logic [KYBER_DU-1:0] c
);
    localparam int YW = 28;
    localparam int QW = 16;
    localparam int PW = YW + 33;
    // floor(2^32/q): estimate is floor(y/q) or one below it for y < 2^28
    localparam logic [32:0]   RECIP  = 33'((64'd1 << 32) / KYBER_Q);
    localparam logic [YW-1:0] Q_Y    = YW'(KYBER_Q);
    localparam logic [YW-1:0] HALF_Q = YW'(KYBER_Q / 2);

    logic [YW-1:0]       xr;
    logic [YW-1:0]       y;
    logic [YW-1:0]       rem;
    logic [QW-1:0]       qe;
    logic [KYBER_DU-1:0] qt;

    // Reduce once, scale, divide by q, then keep only the low d bits
    always_comb begin
        xr = {{(YW-16){1'b0}}, x};
        if (xr >= Q_Y) xr = xr - Q_Y;
        y   = (is_v ? (xr << KYBER_DV) : (xr << KYBER_DU)) + HALF_Q;
        qe  = QW'((PW'(y) * PW'(RECIP)) >> 32);
        rem = y - YW'(qe) * Q_Y;
        qt  = (rem >= Q_Y) ? KYBER_DU'(qe + QW'(1)) : KYBER_DU'(qe);
        c   = '0;
        for (int i = 0; i < KYBER_DU; i++)
            c[i] = qt[i] & (!is_v || (i < KYBER_DV));
    end
endmodule

module state_compress #(
    parameter int KYBER_Q      = 3329,
    parameter int KYBER_DU     = 10,
    parameter int KYBER_DV     = 4,
    parameter int i_Add_Length = 128,
    parameter int o_Cmp_Length = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [i_Add_Length-1:0] Add_RData,
    output logic [7:0]              Add_RAd,
    output logic                    Cmp_outready,
    output logic [7:0]              Cmp_WAd,
    output logic [o_Cmp_Length-1:0] Cmp_WData,
    output logic                    Function_done
);
    localparam int       NUM_LANES = i_Add_Length / 16;
    localparam logic [6:0] LAST_N  = 7'd95;
    localparam logic [6:0] V_BASE  = 7'd64;

    typedef enum logic [2:0] {IDLE, RD, WAIT, CALC, CALC2, WR, DONE} state_t;

`ifdef STATE_COMPRESS_PIPE_EN
    localparam state_t LOAD_ST = CALC2;
`else
    localparam state_t LOAD_ST = CALC;
`endif

    state_t state, nstate;
    logic [6:0] n;
    logic       is_v;
    logic [NUM_LANES-1:0][15:0]         lane_x;
    logic [NUM_LANES-1:0][KYBER_DU-1:0] lane_c;
    logic [NUM_LANES-1:0][KYBER_DU-1:0] pack_src;
    logic [o_Cmp_Length-1:0]            wdata;

    assign is_v    = (n >= V_BASE);
    assign Add_RAd = {1'b0, n};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            assign lane_x[g] = Add_RData[16*g +: 16];
            state_compress_lane #(
                .KYBER_Q (KYBER_Q),
                .KYBER_DU(KYBER_DU),
                .KYBER_DV(KYBER_DV)
            ) u_lane (
                .x   (lane_x[g]),
                .is_v(is_v),
                .c   (lane_c[g])
            );
        end
    endgenerate

`ifdef STATE_COMPRESS_PIPE_EN
    logic [NUM_LANES-1:0][KYBER_DU-1:0] quot_q;

    // Capture the lane quotients at the end of CALC; CALC2 packs from here
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                quot_q <= '0;
        else if (state == CALC) quot_q <= lane_c;
    end
    assign pack_src = quot_q;
`else
    assign pack_src = lane_c;
`endif

    // Pack lanes at d bits each; bits above 8*d stay zero
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (is_v) wdata[KYBER_DV*i +: KYBER_DV] = pack_src[i][KYBER_DV-1:0];
            else      wdata[KYBER_DU*i +: KYBER_DU] = pack_src[i];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state logic; enable only matters in IDLE
    always_comb begin
        nstate = state;
        case (state)
            IDLE:  if (enable) nstate = RD;
            RD:    nstate = WAIT;
            WAIT:  nstate = CALC;
`ifdef STATE_COMPRESS_PIPE_EN
            CALC:  nstate = CALC2;
`else
            CALC:  nstate = WR;
`endif
            CALC2: nstate = WR;
            WR:    nstate = (n == LAST_N) ? DONE : RD;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Word index: advance after each write, rewind once the pass completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               n <= '0;
        else if (state == WR && n != LAST_N)   n <= n + 7'd1;
        else if (state == DONE)                n <= '0;
    end

    // Output word/address registers hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Cmp_WData <= '0;
            Cmp_WAd   <= '0;
        end else if (state == LOAD_ST) begin
            Cmp_WData <= wdata;
            Cmp_WAd   <= {1'b0, n};
        end
    end

    assign Cmp_outready  = (state == WR);
    assign Function_done = (state == DONE);
endmodule

// File: tb/tb_state_compress.sv
// Bench for state_compress: BRAM model, per-cycle output log, arithmetic
// reference model, constant vector table and multi-cycle reset/enable cases.
module tb_state_compress;
    localparam int Q    = 3329;
    localparam int NW   = 96;
    localparam int LOGN = 1024;
`ifdef STATE_COMPRESS_PIPE_EN
    localparam int P = 5;
`else
    localparam int P = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [127:0] Add_RData;
    logic [7:0]   Add_RAd;
    logic         Cmp_outready;
    logic [7:0]   Cmp_WAd;
    logic [79:0]  Cmp_WData;
    logic         Function_done;

    state_compress dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .Add_RData    (Add_RData),
        .Add_RAd      (Add_RAd),
        .Cmp_outready (Cmp_outready),
        .Cmp_WAd      (Cmp_WAd),
        .Cmp_WData    (Cmp_WData),
        .Function_done(Function_done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:NW-1][0:7];

    function automatic logic [127:0] word_of(input int a);
        logic [127:0] w;
        w = '0;
        if (a < NW)
            for (int i = 0; i < 8; i++) w[16*i +: 16] = mem[a][i];
        return w;
    endfunction

    // Add BRAM: one-cycle registered read
    always @(posedge clk) Add_RData <= word_of(int'(Add_RAd));

    // Reference: round(x*2^d/q) mod 2^d computed with plain integer division
    function automatic logic [79:0] model_word(input int n);
        logic [79:0] w;
        longint x, c, m;
        int d;
        w = '0;
        d = (n < 64) ? 10 : 4;
        m = longint'(1) << d;
        for (int i = 0; i < 8; i++) begin
            x = longint'(mem[n][i]);
            if (x >= Q) x = x - Q;
            c = ((x * m) + Q / 2) / Q;
            c = c % m;
            w = w | (80'(c) << (d * i));
        end
        return w;
    endfunction

    function automatic logic [79:0] pack(input int n, input int lanes[8]);
        logic [79:0] w;
        int d;
        w = '0;
        d = (n < 64) ? 10 : 4;
        for (int i = 0; i < 8; i++) w = w | (80'(lanes[i]) << (d * i));
        return w;
    endfunction

    typedef struct {
        int n;
        int lin[8];
        int lexp[8];
    } vec_t;
    vec_t tbl[4];

    int  n_checks = 0;
    int  n_err    = 0;
    time t0       = 0;

    logic [7:0]  ra_log  [0:LOGN-1];
    logic        or_log  [0:LOGN-1];
    logic [7:0]  wad_log [0:LOGN-1];
    logic [79:0] wd_log  [0:LOGN-1];
    logic        dn_log  [0:LOGN-1];

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance to the next negedge(s), logging outputs by cycle number since t0
    task automatic tick(input int cyc);
        int r;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            r = int'(($time - t0 + 5) / 10);
            if (r >= 0 && r < LOGN) begin
                ra_log[r]  = Add_RAd;
                or_log[r]  = Cmp_outready;
                wad_log[r] = Cmp_WAd;
                wd_log[r]  = Cmp_WData;
                dn_log[r]  = Function_done;
            end
        end
    endtask

    task automatic start_pass(input bit hold);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        t0 = $time;
        for (int i = 0; i < LOGN; i++) begin
            ra_log[i] = '0; or_log[i] = 1'b0; wad_log[i] = '0;
            wd_log[i] = '0; dn_log[i] = 1'b0;
        end
        #1;
        if (!hold) enable = 1'b0;
    endtask

    task automatic fill_random();
        for (int a = 0; a < NW; a++)
            for (int i = 0; i < 8; i++) mem[a][i] = 16'($urandom_range(0, 2 * Q - 1));
    endtask

    // Pass whose enable was sampled at edge 'base' (relative to t0)
    task automatic verify_pass(input int base);
        int rd, wr;
        for (int k = 0; k < NW; k++) begin
            rd = base + P * k + 1;
            wr = base + P * k + P;
            check($sformatf("rd_addr[%0d]", k), 80'(ra_log[rd]), 80'(k));
            check($sformatf("strobe[%0d]", k), 80'(or_log[wr]), 80'(1));
            check($sformatf("wad[%0d]", k), 80'(wad_log[wr]), 80'(k));
            check($sformatf("wdata[%0d]", k), wd_log[wr], model_word(k));
        end
        check($sformatf("done_at_%0d", base + NW * P + 1), 80'(dn_log[base + NW * P + 1]), 80'(1));
    endtask

    task automatic count_pass(input string tag, input int last, input int es, input int ed);
        int ns = 0, nd = 0, herr = 0;
        bit seen = 1'b0;
        logic [79:0] lastw = '0;
        for (int r = 1; r <= last; r++) begin
            if (or_log[r]) begin
                ns++; lastw = wd_log[r]; seen = 1'b1;
            end else if (seen && wd_log[r] !== lastw) begin
                herr++;
            end
            if (dn_log[r]) nd++;
        end
        check({tag, "_strobes"}, 80'(ns), 80'(es));
        check({tag, "_dones"}, 80'(nd), 80'(ed));
        check({tag, "_hold_errs"}, 80'(herr), 80'(0));
    endtask

    task automatic check_table();
        int wr;
        for (int t = 0; t < 4; t++) begin
            wr = P * tbl[t].n + P;
            check($sformatf("tbl%0d_wad", t), 80'(wad_log[wr]), 80'(tbl[t].n));
            check($sformatf("tbl%0d_wdata", t), wd_log[wr], pack(tbl[t].n, tbl[t].lexp));
        end
        wr = P * 64 + P;
        check("v_upper_zero", 80'(wd_log[wr][79:32]), 80'(0));
    endtask

    initial begin
        int rc;
        tbl[0].n = 0;  tbl[0].lin = '{default: 1665}; tbl[0].lexp = '{default: 512};
        tbl[1].n = 64; tbl[1].lin = '{default: 1665}; tbl[1].lexp = '{default: 8};
        tbl[2].n = 5;  tbl[2].lin = '{0, 3328, 832, 3329, 1665, 1, 2000, 3000};
        tbl[2].lexp = '{0, 0, 256, 0, 512, 0, 615, 923};
        tbl[3].n = 70; tbl[3].lin = '{0, 3328, 832, 3329, 1665, 1, 2000, 3000};
        tbl[3].lexp = '{0, 0, 4, 0, 8, 0, 10, 14};

        rst = 1'b1; enable = 1'b0;
        fill_random();
        tick(3);
        check("rst_rad",  80'(Add_RAd), 80'(0));
        check("rst_wad",  80'(Cmp_WAd), 80'(0));
        check("rst_wdata", Cmp_WData, 80'(0));
        check("rst_ready", 80'(Cmp_outready), 80'(0));
        check("rst_done", 80'(Function_done), 80'(0));
        rst = 1'b0;
        tick(3);

        // Single pass: random words plus the constant vectors
        fill_random();
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 8; i++) mem[tbl[t].n][i] = 16'(tbl[t].lin[i]);
        start_pass(1'b0);
        tick(NW * P + 10);
        verify_pass(0);
        count_pass("pass", NW * P + 10, NW, 1);
        check_table();

        // Reset in cycle 150 aborts the pass
        fill_random();
        start_pass(1'b0);
        tick(150);
        check("pre_rst_wad", 80'(Cmp_WAd), 80'((150 - P) / P));
        #2 rst = 1'b1;
        #1;
        check("arst_rad",   80'(Add_RAd), 80'(0));
        check("arst_wad",   80'(Cmp_WAd), 80'(0));
        check("arst_wdata", Cmp_WData, 80'(0));
        check("arst_ready", 80'(Cmp_outready), 80'(0));
        check("arst_done",  80'(Function_done), 80'(0));
        tick(3);
        rst = 1'b0;
        tick(30);
        rc = 0;
        for (int r = 151; r <= 183; r++) rc += int'(or_log[r]);
        check("post_rst_strobes", 80'(rc), 80'(0));
        rc = 0;
        for (int r = 1; r <= 183; r++) rc += int'(dn_log[r]);
        check("aborted_dones", 80'(rc), 80'(0));
        check("idle_rad", 80'(Add_RAd), 80'(0));
        start_pass(1'b0);
        tick(NW * P + 10);
        verify_pass(0);
        count_pass("restart", NW * P + 10, NW, 1);

        // enable held high: ignored mid-pass, second pass right after DONE
        fill_random();
        start_pass(1'b1);
        for (int c = 1; c <= 2 * NW * P + 12; c++) begin
            tick(1);
            if (c == 2 * NW * P + 3) enable = 1'b0;
        end
        verify_pass(0);
        verify_pass(NW * P + 2);
        count_pass("hold_en", 2 * NW * P + 12, 2 * NW, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
